cruise_input_conditioner: RTL
=============================

// Module: cruise_input_conditioner
// PURPOSE
//  Front end for the cruise controller. Conditions raw driver inputs before they reach the FSM:
//    - throttle, brake: debounced levels
//    - set, resume, cancel: clean 1-cycle pulses
//    - accel, coast: pulses with auto-repeat while held
//  Brake has priority over every cruise command. All outputs are registered and drive the controller FSM directly.
// PARAMETERS
//  DEBOUNCE_CYCLES  4   consecutive stable sampled cycles required to accept a new input level
//  REPEAT_DELAY     16  cycles from the first accel/coast pulse to the first auto-repeat pulse
//  REPEAT_RATE      4   cycles between auto-repeat pulses once repeating
//  CNT_W            8   width of debounce and repeat counters; must hold max(DEBOUNCE_CYCLES, REPEAT_DELAY)
// PORTS
//  clk          in   1  system clock, rising edge
//  reset        in   1  asynchronous, active-low reset
//  throttle_raw in   1  raw pedal switch (asynchronous)
//  brake_raw    in   1  raw brake switch (asynchronous)
//  set_raw      in   1  raw SET button
//  resume_raw   in   1  raw RESUME button
//  cancel_raw   in   1  raw CANCEL button
//  accel_raw    in   1  raw ACCEL button
//  coast_raw    in   1  raw COAST button
//  throttle     out  1  debounced throttle level
//  brake        out  1  debounced brake level
//  set          out  1  1-cycle pulse on accepted SET press
//  resume       out  1  1-cycle pulse on accepted RESUME press
//  cancel       out  1  1-cycle pulse on accepted CANCEL press
//  accel        out  1  1-cycle pulse on ACCEL press and on each auto-repeat
//  coast        out  1  1-cycle pulse on COAST press and on each auto-repeat
//  input_fault  out  1  level; high while debounced accel and coast are both held
// BEHAVIOUR
//  Reset (reset=0): async clear of all outputs, sync flops, stable levels, counters; repeat FSMs to IDLE.
//  Per channel: 2-flop synchronizer -> debouncer -> edge detect -> output register.
//  Debounce: counter clears whenever the synced value equals the stable level; otherwise it increments.
//    Stable level flips when the counter reaches DEBOUNCE_CYCLES.
//    A glitch shorter than DEBOUNCE_CYCLES produces no output change.
//  Latency: DEBOUNCE_CYCLES+3 rising edges from the first edge sampling a new raw level to the output change
//    (=7 at defaults). Level and pulse outputs are aligned.
//  Pulses fire on rising edges of the stable level only. Releases produce nothing. Pulse width is exactly 1 cycle.
//  Priority, evaluated each cycle on stable levels:
//    - stable brake=1 suppresses set, resume, accel, coast pulses; cancel still passes.
//    - cancel edge in the same cycle as set/resume: only cancel is emitted.
//    - set and resume edges together: only set is emitted.
//  Auto-repeat FSM (one per accel, one per coast), states IDLE/DELAY/REPEAT:
//    IDLE->DELAY on stable rise: emit pulse, load counter=REPEAT_DELAY.
//    DELAY: decrement; at 0 emit pulse, go REPEAT, load REPEAT_RATE.
//    REPEAT: decrement; at 0 emit pulse, reload REPEAT_RATE.
//    Any state->IDLE on stable release, on stable brake=1, or while input_fault=1; no pulse on that cycle.
//    Leaving brake or fault with the button still held does not restart repeat; a fresh press is needed.
//  input_fault: registered AND of stable accel and stable coast; same latency as the levels.
//  Counters saturate and never wrap. With the CNT_W constraint met, no overflow is reachable.
//  Reset mid-operation: outputs drop immediately.
//    After reset release, an input still held re-debounces from stable=0 and yields a fresh edge after full latency.
//    Consequence: a brake held through reset reasserts brake 7 cycles after release.
// TESTING (defaults; t = first edge sampling the raw change)
//  1. set_raw high 20 cycles -> set=1 only at t+7, 1 cycle wide, once; release gives no pulse.
//  2. set_raw high 3 cycles -> no set pulse. set_raw high 4 cycles -> exactly one pulse at t+7.
//  3. accel_raw held 40 cycles -> accel pulses at t+7, t+23, t+27, t+31, ... every 4 cycles;
//     none at or after release+7.
//  4. accel held and repeating, then brake_raw high at t2 -> brake=1 and accel pulses stop from t2+7;
//     set_raw pressed while braking -> no set.
//  5. accel_raw and coast_raw held together -> input_fault=1 at t+7, no accel/coast pulses;
//     release both -> fault=0 after 7 cycles.
//  6. reset=0 during REPEAT with brake_raw held -> all outputs 0 same cycle;
//     after release brake=1 exactly 7 edges later, no accel pulse.

Source files
------------

// File: rtl/cruise_input_conditioner_if.sv
// Signal bundle between the raw driver switches and the cruise input conditioner.
// The bench drives the raw side through master; the conditioner is the slave.
interface cruise_input_conditioner_if;
    logic throttle_raw;
    logic brake_raw;
    logic set_raw;
    logic resume_raw;
    logic cancel_raw;
    logic accel_raw;
    logic coast_raw;
    logic throttle;
    logic brake;
    logic set;
    logic resume;
    logic cancel;
    logic accel;
    logic coast;
    logic input_fault;

    modport master (
        output throttle_raw, brake_raw, set_raw, resume_raw, cancel_raw, accel_raw, coast_raw,
        input  throttle, brake, set, resume, cancel, accel, coast, input_fault
    );

    modport slave (
        input  throttle_raw, brake_raw, set_raw, resume_raw, cancel_raw, accel_raw, coast_raw,
        output throttle, brake, set, resume, cancel, accel, coast, input_fault
    );
endinterface

// File: rtl/cruise_input_conditioner.sv
// Conditions raw cruise-control switches: synchronize, debounce, edge detect,
// apply brake/cancel priority and auto-repeat accel/coast before the controller FSM.
module cruise_input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REPEAT_DELAY    = 16,
    parameter int REPEAT_RATE     = 4,
    parameter int CNT_W           = 8
) (
    input logic                         clk,
    input logic                         reset,
    cruise_input_conditioner_if.slave   bus
);

    localparam int NCH       = 7;
    localparam int CH_BRAKE  = 1;
    localparam int CH_SET    = 2;
    localparam int CH_RESUME = 3;
    localparam int CH_CANCEL = 4;
    localparam int CH_ACCEL  = 5;
    localparam int CH_COAST  = 6;

    localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);
    localparam logic [CNT_W-1:0] DB_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DELAY_LOAD = CNT_W'(REPEAT_DELAY);
    localparam logic [CNT_W-1:0] RATE_LOAD  = CNT_W'(REPEAT_RATE);

    typedef enum logic [1:0] {
        RPT_IDLE,
        RPT_DELAY,
        RPT_REPEAT
    } rpt_state_e;

    logic [NCH-1:0]            raw;
    logic [NCH-1:0]            sync1;
    logic [NCH-1:0]            sync2;
    logic [NCH-1:0]            stable;
    logic [NCH-1:0]            level_s;
    logic [NCH-1:0][CNT_W-1:0] db_cnt;
    logic [NCH-1:CH_SET]       rise_s;
    logic                      brake_lvl;
    logic                      fault_now;
    logic [1:0]                rpt_pulse;

    logic throttle_q, brake_q, set_q, resume_q, cancel_q, fault_q;

    assign raw = {bus.coast_raw, bus.accel_raw, bus.cancel_raw, bus.resume_raw,
                  bus.set_raw, bus.brake_raw, bus.throttle_raw};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    // The DEBOUNCE_CYCLES-th consecutive differing sample flips the stable level.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stable <= '0;
            db_cnt <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (sync2[i] == stable[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] >= DB_LAST) begin
                    stable[i] <= sync2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + ONE;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            level_s <= '0;
            rise_s  <= '0;
        end else begin
            level_s <= stable;
            rise_s  <= stable[NCH-1:CH_SET] & ~level_s[NCH-1:CH_SET];
        end
    end

    assign brake_lvl = level_s[CH_BRAKE];
    assign fault_now = level_s[CH_ACCEL] & level_s[CH_COAST];

    // Cancel wins over set/resume, set wins over resume, brake blocks everything but cancel.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            throttle_q <= 1'b0;
            brake_q    <= 1'b0;
            set_q      <= 1'b0;
            resume_q   <= 1'b0;
            cancel_q   <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            throttle_q <= level_s[0];
            brake_q    <= brake_lvl;
            cancel_q   <= rise_s[CH_CANCEL];
            set_q      <= rise_s[CH_SET] & ~brake_lvl & ~rise_s[CH_CANCEL];
            resume_q   <= rise_s[CH_RESUME] & ~brake_lvl & ~rise_s[CH_CANCEL] & ~rise_s[CH_SET];
            fault_q    <= fault_now;
        end
    end

    for (genvar j = 0; j < 2; j++) begin : g_repeat
        localparam int CH = CH_ACCEL + j;

        rpt_state_e       state_q, state_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             pulse_q, pulse_d;

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                state_q <= RPT_IDLE;
                cnt_q   <= '0;
                pulse_q <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                pulse_q <= pulse_d;
            end
        end

        // Only a fresh rise leaves IDLE, so releasing brake or fault never restarts repeat.
        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            pulse_d = 1'b0;
            if (!level_s[CH] || brake_lvl || fault_now) begin
                state_d = RPT_IDLE;
                cnt_d   = '0;
            end else begin
                case (state_q)
                    RPT_IDLE: begin
                        if (rise_s[CH]) begin
                            pulse_d = 1'b1;
                            state_d = RPT_DELAY;
                            cnt_d   = DELAY_LOAD;
                        end
                    end
                    RPT_DELAY: begin
                        if (cnt_q <= ONE) begin
                            pulse_d = 1'b1;
                            state_d = RPT_REPEAT;
                            cnt_d   = RATE_LOAD;
                        end else begin
                            cnt_d = cnt_q - ONE;
                        end
                    end
                    RPT_REPEAT: begin
                        if (cnt_q <= ONE) begin
                            pulse_d = 1'b1;
                            cnt_d   = RATE_LOAD;
                        end else begin
                            cnt_d = cnt_q - ONE;
                        end
                    end
                    default: begin
                        state_d = RPT_IDLE;
                        cnt_d   = '0;
                    end
                endcase
            end
        end

        assign rpt_pulse[j] = pulse_q;
    end

    assign bus.throttle    = throttle_q;
    assign bus.brake       = brake_q;
    assign bus.set         = set_q;
    assign bus.resume      = resume_q;
    assign bus.cancel      = cancel_q;
    assign bus.accel       = rpt_pulse[0];
    assign bus.coast       = rpt_pulse[1];
    assign bus.input_fault = fault_q;

endmodule
